// File: rtl/pe_v2.sv
// pe_v2: signed weight-bank PE with MAC, LOAD, SYSTOLIC and IDLE modes; saturation enabled by PE_V2_SAT_EN.
// Latency: 1 cycle from input beat to act_o/psum_o and their one-cycle valid pulses.
// Backpressure: none; accepts one beat per cycle in every mode.
module pe_v2 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int WDEPTH = 4,
    parameter int WIDX_W = $clog2(WDEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] act_i,
    input  logic [DATA_W-1:0] wgt_i,
    input  logic [WIDX_W-1:0] wsel_i,
    input  logic [ACC_W-1:0]  psum_i,
    output logic [DATA_W-1:0] act_o,
    output logic              act_valid_o,
    output logic [ACC_W-1:0]  psum_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              sat_o
);
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        MODE_MAC  = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_SYS  = 2'd2,
        MODE_IDLE = 2'd3
    } mode_e;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_BUSY = 1'b1
    } acc_state_e;

    mode_e                     mode;
    acc_state_e                state_q, state_d;
    logic signed [DATA_W-1:0]  wslot [WDEPTH];
    logic signed [DATA_W-1:0]  act_s;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          mac_sum;
    logic [ACC_W-1:0]          sys_sum;

    assign mode     = mode_e'(mode_i);
    assign act_s    = act_i;
    assign prod     = PW'(act_s) * PW'(wslot[wsel_i]);
    assign prod_ext = ACC_W'(prod);

`ifdef PE_V2_SAT_EN
    // Add in ACC_W+1 bits; a mismatch of the top two bits means the signed result left the range.
    function automatic logic [ACC_W-1:0] fit_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] w;
        w = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (w[ACC_W] != w[ACC_W-1])
            return w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return w[ACC_W-1:0];
    endfunction

    function automatic logic add_ovf(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] w;
        w = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        return w[ACC_W] ^ w[ACC_W-1];
    endfunction

    logic sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (in_valid && ((mode == MODE_MAC && add_ovf(acc_q, prod_ext)) ||
                                  (mode == MODE_SYS && add_ovf(psum_i, prod_ext)))) begin
            sat_q <= 1'b1;
        end
    end

    assign mac_sum = fit_add(acc_q, prod_ext);
    assign sys_sum = fit_add(psum_i, prod_ext);
    assign sat_o   = sat_q;
`else
    assign mac_sum = acc_q + prod_ext;
    assign sys_sum = psum_i + prod_ext;
    assign sat_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (in_valid && mode == MODE_MAC)
            state_d = in_last ? ACC_IDLE : ACC_BUSY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy_o = (state_q == ACC_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wslot       <= '{default: '0};
            acc_q       <= '0;
            act_o       <= '0;
            act_valid_o <= 1'b0;
            psum_o      <= '0;
            out_valid_o <= 1'b0;
        end else begin
            act_valid_o <= 1'b0;
            out_valid_o <= 1'b0;
            if (in_valid) begin
                case (mode)
                    MODE_MAC: begin
                        act_o       <= act_i;
                        act_valid_o <= 1'b1;
                        if (in_last) begin
                            psum_o      <= mac_sum;
                            out_valid_o <= 1'b1;
                            acc_q       <= '0;
                        end else begin
                            acc_q <= mac_sum;
                        end
                    end
                    MODE_LOAD: wslot[wsel_i] <= wgt_i;
                    // Pass-through leaves the accumulator alone so a paused dot product can resume.
                    MODE_SYS: begin
                        psum_o      <= sys_sum;
                        out_valid_o <= 1'b1;
                        act_o       <= act_i;
                        act_valid_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/pe_v2.md
# pe_v2

Parametrised second-generation processing element for the convolution core.
- Holds a small bank of signed weights and runs in one of three modes: local multiply-accumulate, weight load, or systolic partial-sum pass-through.
- All outputs are registered; activations are forwarded to the neighbouring PE.
- Slots into the same row/column tiling as the current PE, with wider accumulation, explicit valid handshakes and optional saturation.

## Interface
Parameters:
- DATA_W, 8: activation and weight width, signed two's complement.
- ACC_W, 20: accumulator and partial-sum width, signed. Must be >= 2*DATA_W.
- WDEPTH, 4: number of weight slots, >= 2.
- WIDX_W, $clog2(WDEPTH): slot index width. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode_i  in  2  operating mode: 0 MAC, 1 LOAD, 2 SYSTOLIC, 3 IDLE.
- in_valid  in  1  input beat qualifier.
- in_last  in  1  last beat of a dot product; MAC mode only.
- act_i  in  DATA_W  activation.
- wgt_i  in  DATA_W  weight data for LOAD.
- wsel_i  in  WIDX_W  weight slot for LOAD write and MAC/SYSTOLIC read.
- psum_i  in  ACC_W  upstream partial sum, SYSTOLIC mode.
- act_o  out  DATA_W  registered activation forwarded to the neighbour.
- act_valid_o  out  1  act_o qualifier, one-cycle pulse per beat.
- psum_o  out  ACC_W  result or partial sum.
- out_valid_o  out  1  psum_o qualifier, one-cycle pulse per beat.
- busy_o  out  1  dot product in progress.
- sat_o  out  1  sticky overflow flag.

## Operation
Reset values:
- All outputs are 0.
- Accumulator is 0 and all weight slots are 0.
- FSM is in ACC_IDLE.

Beat rules:
- A beat is any cycle with in_valid=1.
- Cycles with in_valid=0 change no state; act_valid_o and out_valid_o are 0 in those cycles.

Arithmetic:
- prod = act_i * wslot[wsel_i], full 2*DATA_W signed, sign-extended to ACC_W.

LOAD beat:
- Writes wslot[wsel_i] <= wgt_i.
- No output valids. Accumulator and FSM are untouched.

MAC beat:
- Computes sum = acc + prod.
- in_last=0: acc <= sum; FSM goes to ACC_BUSY.
- in_last=1: psum_o <= sum; out_valid_o=1; acc <= 0; FSM goes to ACC_IDLE.
- Every MAC beat also sets act_o <= act_i and act_valid_o=1.

SYSTOLIC beat:
- psum_o <= psum_i + prod; out_valid_o=1.
- act_o <= act_i; act_valid_o=1.
- Accumulator and FSM are untouched, so a pending dot product resumes when the bank returns to MAC.

IDLE:
- Holds all state; valids are 0.

FSM:
- ACC_IDLE -> ACC_BUSY on a MAC beat with in_last=0.
- ACC_BUSY -> ACC_IDLE on a MAC beat with in_last=1.
- busy_o = (state == ACC_BUSY).
- A single-beat dot product (in_last=1 from ACC_IDLE) produces prod as its result.

Boundary conditions:
- LOAD to the slot currently being used mid-dot-product is allowed; it takes effect from the next MAC beat.
- Mode may change on any cycle; the new mode applies to the beat in that cycle.
- When out_valid_o=0, psum_o holds its last value; act_o behaves the same way.
- Reset assertion mid-operation clears everything immediately, asynchronously, including weight slots.

## Timing
- Latency is 1 cycle from input beat to act_o, psum_o and their valids.
- Throughput is one beat per cycle in every mode, with no back-pressure.
- Weight write is visible to a MAC/SYSTOLIC beat in the following cycle.
- sat_o rises in the cycle the overflowing result is registered.

## Configuration
Macro PE_V2_SAT_EN.

Defined:
- Every ACC_W addition (acc+prod, psum_i+prod) clamps to the signed range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Any clamp sets sat_o, which stays 1 until reset.

Undefined:
- Additions wrap modulo 2^ACC_W.
- sat_o is tied to 0.

## Test plan
- Load slots 0..3 with 2, -3, 4, 5. Run MAC beats act=1,2,3 on slot 0, in_last on the 3rd -> one cycle later psum_o=12, out_valid_o=1 for exactly one cycle. busy_o is 1 after beat 1 and 0 after beat 3.
- SYSTOLIC with slot 1 = -3, psum_i=100, act_i=7 -> next cycle psum_o=79, act_o=7, both valids 1 for one cycle.
- DATA_W=8, ACC_W=16, slot 0 = -128, three MAC beats act=-128 (last on the 3rd):
  - With PE_V2_SAT_EN: psum_o=32767, sat_o=1 and remains 1.
  - Without it: psum_o=-16384, sat_o=0.
- MAC beats act=2, 3 on slot 3 (=5), interleaved with in_valid=0 gaps, an IDLE cycle, a LOAD of slot 2=9 and a SYSTOLIC beat; then act=1 with in_last -> psum_o=30. The SYSTOLIC result is independent of the accumulator.
- Two MAC beats, then rst_n low for one cycle mid-dot-product -> all outputs 0, busy_o=0, slots 0. Reload slot 0=5, single MAC beat act=3 with in_last -> psum_o=15.
